mat_operand_loader: RTL and testbench

Upstream operand stage for the matrix-multiply engine. Accepts matrices A and B as one valid/ready word stream, stores A by rows and B by columns (transposed), and pulses `start_cmd` once both are loaded. During compute it serves the engine's row and column requests with zero-latency vector reads. It blocks new input until the engine reports `exec_done`.

---
 rtl/matmul_pkg.sv | 15 +
 rtl/mat_operand_bank.sv | 35 +++
 rtl/mat_operand_loader.sv | 120 ++++++++++++
 tb/tb_mat_operand_loader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared constants and types for the matrix-multiply engine.
// The engine and the operand loader both take their default widths from here.
package matmul_pkg;

    localparam int DEF_DATA_BIT_WIDTH  = 32;
    localparam int DEF_DIM_INDEX_WIDTH = 3;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        START,
        COMPUTE
    } loader_state_t;

endpackage

// File: rtl/mat_operand_bank.sv
// N x N operand register bank with one element write port.
// Reads return a whole vector combinationally.
module mat_operand_bank
    import matmul_pkg::*;
#(
    parameter int DATA_BIT_WIDTH  = DEF_DATA_BIT_WIDTH,
    parameter int DIM_INDEX_WIDTH = DEF_DIM_INDEX_WIDTH,
    parameter int DIM_SIZE        = 2 ** DIM_INDEX_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_en,
    input  logic [DIM_INDEX_WIDTH-1:0]         wr_vec,
    input  logic [DIM_INDEX_WIDTH-1:0]         wr_elem,
    input  logic [DATA_BIT_WIDTH-1:0]          wr_data,
    input  logic [DIM_INDEX_WIDTH-1:0]         rd_vec,
    output logic [DIM_SIZE*DATA_BIT_WIDTH-1:0] rd_data
);

    logic [DIM_SIZE*DATA_BIT_WIDTH-1:0] mem [DIM_SIZE];

    // rst_n is active-high in this codebase despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int v = 0; v < DIM_SIZE; v++) begin
                mem[v] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_vec][wr_elem*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] <= wr_data;
        end
    end

    assign rd_data = mem[rd_vec];

endmodule

// File: rtl/mat_operand_loader.sv
// Operand loader: streams A (row-major) and B (stored transposed),
// fires start_cmd, then holds operands until the engine reports done.
module mat_operand_loader
    import matmul_pkg::*;
#(
    parameter int DATA_BIT_WIDTH  = DEF_DATA_BIT_WIDTH,
    parameter int DIM_INDEX_WIDTH = DEF_DIM_INDEX_WIDTH,
    parameter int DIM_SIZE        = 2 ** DIM_INDEX_WIDTH,
    parameter int ELEM_ADDR_WIDTH = 2 * DIM_INDEX_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    input  logic [DATA_BIT_WIDTH-1:0]          in_data,
    output logic                               in_ready,
    input  logic [DIM_INDEX_WIDTH-1:0]         next_row_req,
    input  logic [DIM_INDEX_WIDTH-1:0]         next_col_req,
    output logic [DIM_SIZE*DATA_BIT_WIDTH-1:0] row_data_out,
    output logic [DIM_SIZE*DATA_BIT_WIDTH-1:0] col_data_out,
    output logic                               start_cmd,
    input  logic                               exec_done,
    output logic                               busy
);

    loader_state_t state, state_nxt;

    logic [ELEM_ADDR_WIDTH-1:0] elem_cnt;
    logic [DIM_INDEX_WIDTH-1:0] row_idx;
    logic [DIM_INDEX_WIDTH-1:0] col_idx;
    logic                       last_elem;
    logic                       xfer;
    logic                       wr_a;
    logic                       wr_b;

    assign row_idx   = elem_cnt[ELEM_ADDR_WIDTH-1 -: DIM_INDEX_WIDTH];
    assign col_idx   = elem_cnt[DIM_INDEX_WIDTH-1:0];
    assign last_elem = &elem_cnt;
    assign xfer      = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= LOAD_A;
            elem_cnt <= '0;
        end else begin
            state <= state_nxt;
            // N*N-1 is all ones, so the increment wraps to 0 by itself.
            if (xfer) begin
                elem_cnt <= elem_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        start_cmd = 1'b0;
        busy      = 1'b0;
        wr_a      = 1'b0;
        wr_b      = 1'b0;
        unique case (state)
            LOAD_A: begin
                in_ready = 1'b1;
                wr_a     = in_valid;
                if (in_valid && last_elem) begin
                    state_nxt = LOAD_B;
                end
            end
            LOAD_B: begin
                in_ready = 1'b1;
                wr_b     = in_valid;
                if (in_valid && last_elem) begin
                    state_nxt = START;
                end
            end
            START: begin
                start_cmd = 1'b1;
                busy      = 1'b1;
                state_nxt = COMPUTE;
            end
            COMPUTE: begin
                busy = 1'b1;
                if (exec_done) begin
                    state_nxt = LOAD_A;
                end
            end
        endcase
    end

    mat_operand_bank #(
        .DATA_BIT_WIDTH (DATA_BIT_WIDTH),
        .DIM_INDEX_WIDTH(DIM_INDEX_WIDTH),
        .DIM_SIZE       (DIM_SIZE)
    ) a_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_a),
        .wr_vec (row_idx),
        .wr_elem(col_idx),
        .wr_data(in_data),
        .rd_vec (next_row_req),
        .rd_data(row_data_out)
    );

    // B is kept by columns so the engine gets a column in one read.
    mat_operand_bank #(
        .DATA_BIT_WIDTH (DATA_BIT_WIDTH),
        .DIM_INDEX_WIDTH(DIM_INDEX_WIDTH),
        .DIM_SIZE       (DIM_SIZE)
    ) b_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_b),
        .wr_vec (col_idx),
        .wr_elem(row_idx),
        .wr_data(in_data),
        .rd_vec (next_col_req),
        .rd_data(col_data_out)
    );

endmodule

// File: tb/tb_mat_operand_loader.sv
// Directed bench for mat_operand_loader: full-rate and gapped loads,
// compute lockout, ignored exec_done and mid-load reset.
module tb_mat_operand_loader;

    localparam int DW = 32;
    localparam int IW = 3;
    localparam int N  = 8;
    localparam int VW = N * DW;

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b1;
    logic          in_valid     = 1'b0;
    logic [DW-1:0] in_data      = '0;
    logic          exec_done    = 1'b0;
    logic [IW-1:0] next_row_req = '0;
    logic [IW-1:0] next_col_req = '0;
    logic          in_ready;
    logic          start_cmd;
    logic          busy;
    logic [VW-1:0] row_data_out;
    logic [VW-1:0] col_data_out;

    int            checks      = 0;
    int            errors      = 0;
    int            start_total = 0;
    int            excl_bad    = 0;
    int            accepted;
    int            cycles;
    int            s0;
    logic [DW-1:0] stim [128];
    logic [VW-1:0] saved_row;
    logic [VW-1:0] unit;

    mat_operand_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .next_row_req(next_row_req),
        .next_col_req(next_col_req),
        .row_data_out(row_data_out),
        .col_data_out(col_data_out),
        .start_cmd   (start_cmd),
        .exec_done   (exec_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_cmd) start_total++;
        if (busy && in_ready) excl_bad++;
    end

    task automatic check(input string tag, input logic [VW-1:0] got,
                         input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] a_row(input int r);
        logic [VW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = stim[r*N + k];
        return v;
    endfunction

    function automatic logic [VW-1:0] b_col(input int c);
        logic [VW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = stim[N*N + k*N + c];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            next_row_req = IW'(i);
            next_col_req = IW'(i);
            #1;
            check($sformatf("%s row %0d", tag, i), row_data_out, a_row(i));
            check($sformatf("%s col %0d", tag, i), col_data_out, b_col(i));
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < N; i++) begin
            next_row_req = IW'(i);
            next_col_req = IW'(i);
            #1;
            check($sformatf("%s row %0d", tag, i), row_data_out, '0);
            check($sformatf("%s col %0d", tag, i), col_data_out, '0);
        end
    endtask

    // Stream stim[first..last]; duty in percent, optional exec_done in gaps.
    task automatic stream(input string tag, input int first, input int last,
                          input int duty, input bit pulse, output int n_cyc);
        int i      = first;
        int budget = 3000;
        n_cyc = 0;
        while (i <= last && budget > 0) begin
            in_valid  = ($urandom_range(99) < duty);
            in_data   = stim[i];
            exec_done = pulse && !in_valid && ($urandom_range(2) == 0);
            if (in_valid && in_ready) begin
                i++;
                accepted++;
            end
            step();
            n_cyc++;
            budget--;
        end
        in_valid  = 1'b0;
        exec_done = 1'b0;
        check({tag, " words"}, VW'(i), VW'(last + 1));
    endtask

    initial begin
        #2;
        check("rst in_ready", VW'(in_ready), VW'(1));
        check("rst busy", VW'(busy), VW'(0));
        check("rst start", VW'(start_cmd), VW'(0));
        check_zero("rst");
        step();
        rst_n = 1'b0;
        step();

        // A[r][c] = r*8+c, B = identity, full rate.
        for (int i = 0; i < 64; i++) stim[i] = DW'(i);
        for (int i = 0; i < 64; i++) stim[64 + i] = DW'((i / N) == (i % N));
        accepted = 0;
        s0 = start_total;
        stream("t1", 0, 127, 100, 1'b0, cycles);
        check("t1 cycles", VW'(cycles), VW'(128));
        check("t1 early start", VW'(start_total - s0), VW'(0));
        check("t1 start", VW'(start_cmd), VW'(1));
        check("t1 ready", VW'(in_ready), VW'(0));
        check("t1 busy", VW'(busy), VW'(1));
        step();
        check("t1 start once", VW'(start_cmd), VW'(0));
        check("t1 busy compute", VW'(busy), VW'(1));
        check_all("t1");
        next_col_req = 3'd3;
        unit = '0;
        unit[3*DW] = 1'b1;
        #1;
        check("t1 unit col3", col_data_out, unit);

        // Hold in_valid into COMPUTE; nothing may be written.
        next_row_req = '0;
        saved_row = a_row(0);
        for (int i = 0; i < 64; i++) stim[i] = DW'(i + 100);
        for (int i = 0; i < 64; i++) stim[64 + i] = DW'(i % N);
        in_valid = 1'b1;
        in_data  = stim[0];
        repeat (3) step();
        check("t2 ready locked", VW'(in_ready), VW'(0));
        check("t2 row0 kept", row_data_out, saved_row);
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        check("t2 ready after done", VW'(in_ready), VW'(1));
        check("t2 busy after done", VW'(busy), VW'(0));
        accepted = 1;
        step();
        in_valid = 1'b0;
        check("t2 word0", VW'(row_data_out[DW-1:0]), VW'(100));

        // Gapped input with exec_done noise during LOAD_A/LOAD_B.
        s0 = start_total;
        stream("t3", 1, 127, 50, 1'b1, cycles);
        check("t3 accepted", VW'(accepted), VW'(128));
        check("t3 start", VW'(start_cmd), VW'(1));
        repeat (4) step();
        check("t3 start pulses", VW'(start_total - s0), VW'(1));
        next_col_req = 3'd5;
        #1;
        check("t3 col5", col_data_out, {N{DW'(5)}});
        check_all("t3");

        // Reset after 70 transfers, then a clean reload.
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        s0 = start_total;
        stream("t4 part", 0, 69, 100, 1'b0, cycles);
        rst_n = 1'b1;
        #1;
        check("t4 rst ready", VW'(in_ready), VW'(1));
        check("t4 rst busy", VW'(busy), VW'(0));
        check("t4 rst start", VW'(start_cmd), VW'(0));
        check_zero("t4 rst");
        step();
        rst_n = 1'b0;
        for (int i = 0; i < 128; i++) stim[i] = DW'(i * 3 + 7);
        stream("t4", 0, 127, 100, 1'b0, cycles);
        repeat (4) step();
        check("t4 start pulses", VW'(start_total - s0), VW'(1));
        check_all("t4");
        check("excl busy ready", VW'(excl_bad), VW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
